// File: rtl/mem_pkg.sv
// Shared MEM-stage definitions: load/store width codes, store FSM states and
// the store-size helper used by both the aligner and the FSM.
package mem_pkg;

  localparam logic [3:0] CTRL_LB  = 4'b0000;
  localparam logic [3:0] CTRL_LH  = 4'b0001;
  localparam logic [3:0] CTRL_LW  = 4'b0010;
  localparam logic [3:0] CTRL_LD  = 4'b0011;
  localparam logic [3:0] CTRL_LBU = 4'b0100;
  localparam logic [3:0] CTRL_LHU = 4'b0101;
  localparam logic [3:0] CTRL_LWU = 4'b0110;

  // Store codes all have ctrl[3] set.
  localparam logic [3:0] CTRL_SD  = 4'b1000;
  localparam logic [3:0] CTRL_SW  = 4'b1001;
  localparam logic [3:0] CTRL_SH  = 4'b1010;
  localparam logic [3:0] CTRL_SB  = 4'b1011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_B = 2'd2,
    RESP   = 2'd3
  } st_state_t;

  // Bytes written by a store code; 0 marks an illegal code.
  function automatic logic [3:0] store_size(input logic [3:0] ctrl);
    case (ctrl)
      CTRL_SD: return 4'd8;
      CTRL_SW: return 4'd4;
      CTRL_SH: return 4'd2;
      CTRL_SB: return 4'd1;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/store_align.sv
// Places right-aligned store data into its byte lanes and builds the byte
// mask; write-side mirror of the load lane extractor.
module store_align
  import mem_pkg::*;
(
  input  logic [2:0]  offset,
  input  logic [3:0]  ctrl,
  input  logic [63:0] data,
  output logic [7:0]  wmask,
  output logic [63:0] wdata,
  output logic        misaligned,
  output logic        illegal
);

  logic [3:0]  size;
  logic [3:0]  size_m1;
  logic [15:0] mask_wide;

  always_comb begin
    size       = store_size(ctrl);
    size_m1    = size - 4'd1;
    illegal    = (size == 4'd0);
    // Sizes are powers of two, so "offset mod size" is just the low bits.
    misaligned = !illegal && (|(offset & size_m1[2:0]));
    mask_wide  = ((16'd1 << size) - 16'd1) << offset;
    wmask      = mask_wide[7:0];
    wdata      = data << {offset, 3'b000};
  end

endmodule

// File: rtl/store_unit.sv
// MEM-stage store path: accepts one store, issues an aligned write beat with
// byte mask, waits for the write response (with timeout) and reports done/err.
module store_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [3:0]        st_ctrl,
  output logic              st_done,
  output logic              st_err,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_bvalid,
  input  logic              mem_bresp
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  st_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             err_q, err_d;
  logic             load_beat;

  logic [7:0]        al_wmask;
  logic [DATA_W-1:0] al_wdata;
  logic              al_misaligned;
  logic              al_illegal;

  store_align u_align (
    .offset     (st_addr[2:0]),
    .ctrl       (st_ctrl),
    .data       (st_data),
    .wmask      (al_wmask),
    .wdata      (al_wdata),
    .misaligned (al_misaligned),
    .illegal    (al_illegal)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d   = state_q;
    cnt_d     = '0;
    err_d     = err_q;
    load_beat = 1'b0;
    case (state_q)
      IDLE: begin
        if (st_valid) begin
          if (al_illegal || al_misaligned) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d   = ISSUE;
            err_d     = 1'b0;
            load_beat = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (mem_wready) begin
          if (mem_bvalid) begin
            state_d = RESP;
            err_d   = mem_bresp;
          end else begin
            state_d = WAIT_B;
          end
        end
      end
      WAIT_B: begin
        if (mem_bvalid) begin
          state_d = RESP;
          err_d   = mem_bresp;
        end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      // The beat is frozen at accept so it stays stable until mem_wready.
      if (load_beat) begin
        mem_waddr <= {st_addr[ADDR_W-1:3], 3'b000};
        mem_wdata <= al_wdata;
        mem_wmask <= al_wmask;
      end
    end
  end

  assign st_ready   = (state_q == IDLE) && !rst;
  assign st_done    = (state_q == RESP);
  assign st_err     = (state_q == RESP) && err_q;
  assign mem_wvalid = (state_q == ISSUE);

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed cases plus randomized stores
// compared against a byte-level reference model of the store rules.
module tb_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [63:0] st_addr;
  logic [63:0] st_data;
  logic [3:0]  st_ctrl;
  logic        st_done;
  logic        st_err;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_bvalid;
  logic        mem_bresp;

  int n_tests = 0;
  int n_fail  = 0;

  store_unit #(.TIMEOUT_CYCLES(TO), .ADDR_W(64), .DATA_W(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_ctrl    (st_ctrl),
    .st_done    (st_done),
    .st_err     (st_err),
    .mem_wvalid (mem_wvalid),
    .mem_wready (mem_wready),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_bvalid (mem_bvalid),
    .mem_bresp  (mem_bresp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: which bytes a store touches and where its data lands.
  function automatic void model(input logic [63:0] addr, input logic [3:0] ctrl,
                                input logic [63:0] data, output bit legal,
                                output logic [7:0] mask, output logic [63:0] wdata);
    int sz;
    int off;
    off = int'(addr[2:0]);
    case (ctrl)
      4'd8:    sz = 8;
      4'd9:    sz = 4;
      4'd10:   sz = 2;
      4'd11:   sz = 1;
      default: sz = 0;
    endcase
    legal = (sz != 0) && (off % sz == 0);
    mask  = '0;
    for (int i = 0; i < 8; i++)
      if (i >= off && i < off + sz) mask[i] = 1'b1;
    wdata = data << (8 * off);
  endfunction

  // b_wait: 0 = bvalid together with wready, k in 1..TO = bvalid in the k-th
  // WAIT_B cycle, anything larger = no response (timeout).
  task automatic run_store(input string name, input logic [63:0] addr, input logic [63:0] data,
                           input logic [3:0] ctrl, input int wr_wait, input int b_wait,
                           input logic bresp);
    bit          legal;
    logic [7:0]  emask;
    logic [63:0] ewdata;
    logic [63:0] ewaddr;
    logic        eerr;
    model(addr, ctrl, data, legal, emask, ewdata);
    ewaddr = {addr[63:3], 3'b000};

    check({name, ".ready_idle"}, st_ready, 1);
    st_valid = 1'b1; st_addr = addr; st_data = data; st_ctrl = ctrl;
    tick();
    st_valid = 1'b0;
    st_addr  = {$urandom, $urandom};
    st_data  = {$urandom, $urandom};
    st_ctrl  = 4'($urandom);

    if (!legal) begin
      check({name, ".rej_done"}, st_done, 1);
      check({name, ".rej_err"}, st_err, 1);
      check({name, ".rej_wvalid"}, mem_wvalid, 0);
      check({name, ".rej_ready"}, st_ready, 0);
      tick();
      check({name, ".rej_done_clr"}, st_done, 0);
      check({name, ".rej_ready_back"}, st_ready, 1);
      return;
    end

    for (int k = 0; k <= wr_wait; k++) begin
      check({name, ".wvalid"}, mem_wvalid, 1);
      check({name, ".waddr"}, mem_waddr, ewaddr);
      check({name, ".wmask"}, mem_wmask, emask);
      check({name, ".wdata"}, mem_wdata, ewdata);
      check({name, ".busy"}, st_ready, 0);
      check({name, ".no_done"}, st_done, 0);
      st_valid  = 1'($urandom);
      mem_bresp = 1'($urandom);
      if (k < wr_wait) begin
        mem_wready = 1'b0;
        mem_bvalid = 1'($urandom);
      end else begin
        mem_wready = 1'b1;
        mem_bvalid = (b_wait == 0);
        mem_bresp  = bresp;
      end
      tick();
    end
    mem_wready = 1'b0;
    mem_bvalid = 1'b0;

    if (b_wait != 0) begin
      for (int j = 0; j < TO; j++) begin
        check({name, ".waitb_wvalid"}, mem_wvalid, 0);
        check({name, ".waitb_no_done"}, st_done, 0);
        mem_bvalid = (j == b_wait - 1);
        mem_bresp  = (j == b_wait - 1) ? bresp : 1'($urandom);
        tick();
        mem_bvalid = 1'b0;
        if (j == b_wait - 1) break;
      end
    end
    eerr = (b_wait <= TO) ? bresp : 1'b1;

    st_valid = 1'b0;
    check({name, ".done"}, st_done, 1);
    check({name, ".err"}, st_err, eerr);
    check({name, ".resp_busy"}, st_ready, 0);
    tick();
    check({name, ".done_clr"}, st_done, 0);
    check({name, ".ready_back"}, st_ready, 1);
  endtask

  initial begin
    logic [3:0] rc;
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_ctrl = '0;
    mem_wready = 1'b0; mem_bvalid = 1'b0; mem_bresp = 1'b0;

    // Reset state
    tick(); tick();
    check("rst.ready_low", st_ready, 0);
    check("rst.wvalid", mem_wvalid, 0);
    check("rst.done", st_done, 0);
    check("rst.err", st_err, 0);
    check("rst.waddr", mem_waddr, 0);
    check("rst.wmask", mem_wmask, 0);
    check("rst.wdata", mem_wdata, 0);
    rst = 1'b0;
    #1;
    check("rst.ready_first", st_ready, 1);

    // Directed stores
    run_store("sw_basic", 64'h0000_0000_8000_0004, 64'h1122_3344_5566_7788, 4'b1001, 0, 1, 1'b0);
    run_store("sb_lane7", 64'h0000_0000_8000_0107, 64'h0000_0000_0000_00AB, 4'b1011, 0, 1, 1'b0);
    run_store("sh_lane2", 64'h0000_0000_8000_0202, 64'h0000_0000_0000_BEEF, 4'b1010, 1, 2, 1'b0);
    run_store("sh_misal", 64'h0000_0000_8000_0003, 64'h0000_0000_0000_1234, 4'b1010, 0, 1, 1'b0);
    run_store("sd_misal", 64'h0000_0000_8000_0004, 64'h0123_4567_89AB_CDEF, 4'b1000, 0, 1, 1'b0);
    run_store("illegal",  64'h0000_0000_8000_0000, 64'h0000_0000_0000_0055, 4'b0000, 0, 1, 1'b0);
    run_store("sd_stall", 64'h0000_0000_8000_1000, 64'hDEAD_BEEF_CAFE_F00D, 4'b1000, 5, 1, 1'b1);
    run_store("same_cyc", 64'h0000_0000_8000_2008, 64'hFFFF_0000_FFFF_0000, 4'b1000, 2, 0, 1'b1);
    run_store("b_last",   64'h0000_0000_8000_3010, 64'h0000_0000_7777_7777, 4'b1001, 0, TO, 1'b0);
    run_store("timeout",  64'h0000_0000_8000_4000, 64'h0000_0000_0000_00AA, 4'b1011, 0, 99, 1'b0);

    // Handshake inputs in IDLE are ignored
    for (int i = 0; i < 3; i++) begin
      mem_wready = 1'b1; mem_bvalid = 1'b1; mem_bresp = 1'b1;
      tick();
      check("idle_junk.done", st_done, 0);
      check("idle_junk.wvalid", mem_wvalid, 0);
      check("idle_junk.ready", st_ready, 1);
    end
    mem_wready = 1'b0; mem_bvalid = 1'b0; mem_bresp = 1'b0;

    // Reset while in WAIT_B, then a stale response
    st_valid = 1'b1; st_addr = 64'h0000_0000_8000_5000; st_data = 64'h1; st_ctrl = 4'b1000;
    tick();
    st_valid = 1'b0;
    check("rstmid.wvalid", mem_wvalid, 1);
    mem_wready = 1'b1;
    tick();
    mem_wready = 1'b0;
    check("rstmid.in_waitb", mem_wvalid, 0);
    tick();
    rst = 1'b1;
    tick();
    check("rstmid.wvalid_low", mem_wvalid, 0);
    check("rstmid.no_done", st_done, 0);
    check("rstmid.ready_in_rst", st_ready, 0);
    rst = 1'b0; mem_bvalid = 1'b1; mem_bresp = 1'b1;
    #1;
    check("rstmid.ready_after", st_ready, 1);
    tick();
    mem_bvalid = 1'b0; mem_bresp = 1'b0;
    check("rstmid.stale_no_done", st_done, 0);
    check("rstmid.stale_no_err", st_err, 0);
    check("rstmid.ready", st_ready, 1);
    tick();
    check("rstmid.quiet", st_done, 0);

    // Randomized stores
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 5) != 0) rc = 4'd8 + 4'($urandom_range(0, 3));
      else                           rc = 4'($urandom_range(0, 7));
      run_store($sformatf("rnd%0d", n), {$urandom, $urandom}, {$urandom, $urandom}, rc,
                $urandom_range(0, 3), $urandom_range(0, TO + 1), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Write-side counterpart of the MEM-stage load path in the 64-bit NPC core.
- Takes a store request (address, data, width code) from the MEM stage and converts it into an 8-byte-aligned write beat with a byte mask.
- Drives the write handshake to the data-memory port and waits for the write response.
- Reports completion or error back to the pipeline, which stalls on st_ready low.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent in WAIT_B before the store is aborted with error (counter width = clog2(TIMEOUT_CYCLES+1))
ADDR_W, 64, address width
DATA_W, 64, data width; must be 64 (8 mask bits)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
st_valid  in  1  store request valid
st_ready  out  1  unit can accept a request
st_addr  in  64  byte address
st_data  in  64  store data, right-aligned (value sits in the low bytes)
st_ctrl  in  4  width code: 4'b1000 SD, 4'b1001 SW, 4'b1010 SH, 4'b1011 SB; any other code is illegal
st_done  out  1  one-cycle completion pulse
st_err  out  1  error flag, valid only while st_done=1
mem_wvalid  out  1  write beat valid
mem_wready  in  1  memory accepts beat
mem_waddr  out  64  st_addr with bits [2:0] cleared
mem_wdata  out  64  data shifted into byte lanes
mem_wmask  out  8  byte enables
mem_bvalid  in  1  write response valid
mem_bresp  in  1  1 = memory error

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; st_ready=1 on the first cycle after reset (held 0 while rst=1). All of these are 0: st_done, st_err, mem_wvalid, mem_waddr, mem_wdata, mem_wmask, timeout counter.
- Ready: st_ready = (state==IDLE) and not rst.
- Accept: st_valid & st_ready captures addr, data and ctrl into registers. No other request is accepted until the FSM returns to IDLE.
- Size: 8/4/2/1 bytes for SD/SW/SH/SB.
- Alignment check: the store is aligned when addr[2:0] mod size == 0.
- Byte mask: mem_wmask = ((1<<size)-1) << addr[2:0].
- Write data: mem_wdata = st_data << (8*addr[2:0]). Bytes outside the mask are don't-care but are driven with the shifted value.

FSM:
- IDLE
  - Accepted and legal -> ISSUE.
  - Accepted and (misaligned or illegal ctrl) -> RESP with err=1. No memory beat is issued.
- ISSUE
  - mem_wvalid=1; address, data and mask stay stable until mem_wready.
  - On mem_wready: -> WAIT_B.
  - If mem_bvalid is also high in that same cycle: -> RESP with err=mem_bresp.
- WAIT_B
  - Counter increments each cycle.
  - mem_bvalid -> RESP with err=mem_bresp.
  - Counter reaches TIMEOUT_CYCLES without bvalid -> RESP with err=1.
- RESP
  - st_done=1 and st_err=registered err for exactly one cycle, then -> IDLE.
  - st_ready stays 0 during RESP.

Latency: accept at cycle N; mem_wvalid at N+1; with wready at N+1 and bvalid at N+2, st_done is at N+3. A misaligned or illegal store gives st_done at N+1.

Boundary and simultaneous events:
- mem_bvalid in IDLE or ISSUE (without wready) is ignored.
- mem_wready while mem_wvalid=0 is ignored.
- A store with addr[2:0]=7 and SB sets mask bit 7 only.
- SD requires addr[2:0]=0.
- rst asserted mid-operation: on the next edge state=IDLE and mem_wvalid drops. An in-flight response is then ignored because bvalid is ignored in IDLE. No st_done is generated for the aborted store.

Decomposition:
- Shared package mem_pkg holds:
  - load and store ctrl encodings (store codes have ctrl[3]=1)
  - FSM state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT_B=2'd2, RESP=2'd3)
  - helper function for size from ctrl
- One combinational sub-module, store_align (addr[2:0], ctrl, data -> wmask, wdata, misaligned, illegal). It mirrors the load-side lane extraction.
- store_unit itself holds the FSM, capture registers and timeout counter.

Test Plan:
- SW addr=0x8000_0004 data=0x1122_3344_5566_7788, wready and bvalid one cycle later -> waddr=0x8000_0000, wmask=8'hF0, wdata[63:32]=0x5566_7788, st_done at N+3, st_err=0.
- SB addr=0x...07 data=0xAB -> wmask=8'h80, wdata[63:56]=0xAB; SH addr=0x...02 -> wmask=8'h0C.
- SH addr=0x...03, or st_ctrl=4'b0000 -> no mem_wvalid, st_done at N+1 with st_err=1.
- SD addr aligned, wready held low 5 cycles -> wvalid, waddr and wdata stable for 5 cycles; then bvalid with bresp=1 -> st_err=1.
- bvalid never arrives (TIMEOUT_CYCLES=4) -> st_done with st_err=1 exactly 4 cycles after entering WAIT_B.
- rst pulsed while in WAIT_B, then stale bvalid -> mem_wvalid=0, no st_done, st_ready=1 after rst deasserts.
